// File: rtl/accum_window.sv
// Windowed sample accumulator feeding the accum_avg divider: sums a window of samples,
// launches {sum, count} into div with a start pulse, and paces starts to div's iteration time.
module accum_window #(
   parameter int DATA_W     = 16,
   parameter int WIN_LEN    = 256,
   parameter int DIV_CYCLES = 33
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              flush,
   output logic              div_start,
   output logic [31:0]       div_dividend,
   output logic [31:0]       div_divider,
   output logic              avg_valid
);

   localparam int CNT_W = $clog2(WIN_LEN + 1);
   localparam int TMR_W = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      FULL   = 2'd1,
      LAUNCH = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       sum_q, sum_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              first_launch_q, first_launch_d;
   logic              in_ready_q, in_ready_d;
   logic              div_start_q, div_start_d;
   logic [31:0]       dividend_q, dividend_d;
   logic [31:0]       divider_q, divider_d;
   logic              avg_valid_q, avg_valid_d;

   logic              accept_s;
   logic [31:0]       sum_acc_s;
   logic [CNT_W-1:0]  count_acc_s;
   logic              closed_s;

   // Window contents including the sample accepted this cycle, and the close condition.
   always_comb begin
      accept_s    = in_valid && in_ready_q;
      sum_acc_s   = sum_q + (accept_s ? 32'(in_data) : 32'd0);
      count_acc_s = count_q + (accept_s ? CNT_W'(1) : CNT_W'(0));
      closed_s    = (count_acc_s == CNT_W'(WIN_LEN)) ||
                    (flush && (count_acc_s != CNT_W'(0)));
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM: begin
            if (closed_s) begin
               state_d = (timer_q == TMR_W'(0)) ? LAUNCH : FULL;
            end else begin
               state_d = ACCUM;
            end
         end
         FULL: begin
            if (timer_q == TMR_W'(0)) begin
               state_d = LAUNCH;
            end else begin
               state_d = FULL;
            end
         end
         LAUNCH:  state_d = ACCUM;
         default: state_d = ACCUM;
      endcase

      // Outputs are registered from the next state, so div_start is high during LAUNCH.
      sum_d      = sum_acc_s;
      count_d    = count_acc_s;
      dividend_d = dividend_q;
      divider_d  = divider_q;
      if (state_d == LAUNCH) begin
         sum_d      = 32'd0;
         count_d    = CNT_W'(0);
         dividend_d = sum_acc_s;
         divider_d  = 32'(count_acc_s);
         timer_d    = TMR_W'(DIV_CYCLES - 1);
      end else if (timer_q != TMR_W'(0)) begin
         timer_d    = timer_q - TMR_W'(1);
      end else begin
         timer_d    = TMR_W'(0);
      end

      div_start_d    = (state_d == LAUNCH);
      in_ready_d     = (state_d == ACCUM);
      avg_valid_d    = div_start_q && !first_launch_q;
      first_launch_d = first_launch_q && !div_start_q;
   end

   // State and output registers; timer starts full because div may still be busy after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ACCUM;
         sum_q          <= 32'd0;
         count_q        <= CNT_W'(0);
         timer_q        <= TMR_W'(DIV_CYCLES);
         first_launch_q <= 1'b1;
         in_ready_q     <= 1'b0;
         div_start_q    <= 1'b0;
         dividend_q     <= 32'd0;
         divider_q      <= 32'd0;
         avg_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         sum_q          <= sum_d;
         count_q        <= count_d;
         timer_q        <= timer_d;
         first_launch_q <= first_launch_d;
         in_ready_q     <= in_ready_d;
         div_start_q    <= div_start_d;
         dividend_q     <= dividend_d;
         divider_q      <= divider_d;
         avg_valid_q    <= avg_valid_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign div_start    = div_start_q;
   assign div_dividend = dividend_q;
   assign div_divider  = divider_q;
   assign avg_valid    = avg_valid_q;

endmodule

// File: tb/tb_accum_window.sv
// Scoreboard bench for accum_window: windows are modelled on accept and checked at div_start.
module tb_accum_window;

   localparam int DW = 16;
   localparam int WL = 4;
   localparam int DC = 33;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          flush = 1'b0;
   logic          in_ready, div_start, avg_valid;
   logic [31:0]   div_dividend, div_divider;

   accum_window #(.DATA_W(DW), .WIN_LEN(WL), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .flush(flush), .div_start(div_start), .div_dividend(div_dividend),
      .div_divider(div_divider), .avg_valid(avg_valid)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] exp_q[$];
   int  m_sum = 0;
   int  m_cnt = 0;
   bit  strm = 1'b0;
   int  rel_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic close_window();
      exp_q.push_back({32'(m_sum), 32'(m_cnt)});
      m_sum = 0;
      m_cnt = 0;
   endtask

   task automatic send(input int d, input bit fl);
      int b;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(d);
      flush    = fl;
      b = 0;
      while (!in_ready && b < 200) begin
         @(negedge clk);
         b++;
      end
      if (b >= 200) chk("accept_timeout", 32'(in_ready), 32'd1);
      m_sum += d;
      m_cnt++;
      if (m_cnt == WL || fl) close_window();
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic flush_only();
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b1;
      if (in_ready && m_cnt > 0) close_window();
      @(posedge clk);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_div_start"}, 32'(div_start), 32'd0);
      chk({tag, "_dividend"}, div_dividend, 32'd0);
      chk({tag, "_divider"}, div_divider, 32'd0);
      chk({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
   endtask

   // Monitor: pops the scoreboard on each start and tracks avg_valid/holdoff timing.
   initial begin : monitor
      bit mon_first = 1'b1;
      bit prev_nf = 1'b0;
      bit last_strm = 1'b0;
      int last_cyc = 0;
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_first = 1'b1;
            prev_nf   = 1'b0;
            last_strm = 1'b0;
         end else begin
            if (avg_valid || prev_nf) chk("avg_valid", 32'(avg_valid), 32'(prev_nf));
            if (div_start) begin
               chk("in_ready_at_start", 32'(in_ready), 32'd0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_start", 32'(div_start), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("dividend", div_dividend, e[63:32]);
                  chk("divider", div_divider, e[31:0]);
               end
               if (mon_first) chk("holdoff_after_rst", 32'((cyc - rel_cyc) >= DC), 32'd1);
               if (strm && last_strm) chk("start_gap", 32'(cyc - last_cyc), 32'(DC));
               last_strm = strm;
               last_cyc  = cyc;
               prev_nf   = !mon_first;
               mon_first = 1'b0;
            end else begin
               prev_nf = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", n_run);
      $fatal(1);
   end

   initial begin : stim
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b0;
      rel_cyc = cyc;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Basic window after the holdoff, then two more (second one fills during holdoff).
      idle(40);
      send(10, 1'b0); send(20, 1'b0); send(30, 1'b0); send(40, 1'b0);
      idle(5);
      for (int i = 0; i < 4; i++) send(1, 1'b0);
      for (int i = 0; i < 4; i++) send(8, 1'b0);
      idle(80);

      // Short window closed by flush, then a flush with an empty window.
      send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
      flush_only();
      idle(40);
      flush_only();
      idle(40);
      chk("flush_empty_no_start", 32'(exp_q.size()), 32'd0);

      // Flush coinciding with an accept.
      send(4, 1'b0); send(5, 1'b0); send(7, 1'b1);
      idle(40);

      // Back-to-back streaming: starts must be exactly DC apart.
      strm = 1'b1;
      for (int i = 0; i < 12; i++) send(i * 3 + 1, 1'b0);
      idle(80);
      strm = 1'b0;
      chk("stream_drained", 32'(exp_q.size()), 32'd0);

      // Reset while a window waits in FULL.
      send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
      send(5, 1'b0); send(6, 1'b0); send(7, 1'b0); send(8, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_outputs_zero("mid_rst");
      exp_q.delete();
      m_sum = 0;
      m_cnt = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rel_cyc = cyc;
      send(9, 1'b0); send(9, 1'b0); send(9, 1'b0); send(9, 1'b0);
      idle(60);
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
